// File: rtl/char_normalizer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : char_normalizer_pkg
// Description : Shared constants, FSM encoding and character class helpers
//               for the character normalizer front end.
// Revision    : 1.0 - initial release
// ============================================================================
package char_normalizer_pkg;

    localparam logic [7:0] C_PAD_CHAR    = 8'h20;
    localparam logic [7:0] C_UPPER_A     = 8'h41;
    localparam logic [7:0] C_UPPER_Z     = 8'h5A;
    localparam logic [7:0] C_LOWER_A     = 8'h61;
    localparam logic [7:0] C_LOWER_Z     = 8'h7A;
    localparam logic [7:0] C_CASE_OFFSET = 8'h20;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    function automatic logic is_upper(input logic [7:0] c);
        return (c >= C_UPPER_A) && (c <= C_UPPER_Z);
    endfunction

    function automatic logic is_lower(input logic [7:0] c);
        return (c >= C_LOWER_A) && (c <= C_LOWER_Z);
    endfunction

endpackage
`default_nettype wire

// File: rtl/char_normalizer_fifo.sv
`default_nettype none
// ============================================================================
// Module      : norm_fifo
// Description : DEPTH x WIDTH synchronous FIFO with combinational head read.
// Revision    : 1.0 - initial release
// ============================================================================
module norm_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int                 C_PTR_W      = $clog2(DEPTH);
    localparam logic [C_PTR_W:0]   C_FULL_COUNT = (C_PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [C_PTR_W-1:0] r_wr_ptr;
    logic [C_PTR_W-1:0] r_rd_ptr;
    logic [C_PTR_W:0]   r_count;
    logic               w_do_push;
    logic               w_do_pop;

    assign full      = (r_count == C_FULL_COUNT);
    assign empty     = (r_count == '0);
    assign w_do_push = push & ~full;
    assign w_do_pop  = pop & ~empty;
    assign pop_data  = r_mem[r_rd_ptr];

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_do_push && w_do_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/char_normalizer.sv
`default_nettype none
// ============================================================================
// Module      : char_normalizer
// Description : Lower-cases letters, collapses separator runs, terminates
//               every stream with a separator and counts words per stream.
// Revision    : 1.0 - initial release
// ============================================================================
module char_normalizer
    import char_normalizer_pkg::*;
#(
    parameter int         DEPTH    = 4,
    parameter logic [7:0] PAD_CHAR = C_PAD_CHAR,
    parameter int         CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [7:0]       out_data,
    output logic             out_valid,
    output logic             out_last,
    input  logic             out_ready,
    output logic             stream_done,
    output logic [CNT_W-1:0] stream_words
);

    state_t           r_state;
    logic             r_prev_sep;
    logic [CNT_W-1:0] r_word_cnt;

    logic             w_full;
    logic             w_empty;
    logic             w_acc;
    logic             w_upper;
    logic             w_letter;
    logic [7:0]       w_char;
    logic             w_push;
    logic [8:0]       w_push_entry;
    logic [8:0]       w_head;
    logic             w_stream_end;
    logic [CNT_W-1:0] w_word_cnt_next;

    assign in_ready = (r_state == ST_RUN) & ~w_full;
    assign w_acc    = in_valid & in_ready;
    assign w_upper  = is_upper(in_data);
    assign w_letter = w_upper | is_lower(in_data);
    assign w_char   = w_upper ? (in_data + C_CASE_OFFSET) : in_data;

    always_comb begin
        w_push          = 1'b0;
        w_push_entry    = {1'b0, PAD_CHAR};
        w_word_cnt_next = r_word_cnt;
        if (r_state == ST_FLUSH) begin
            w_push       = ~w_full;
            w_push_entry = {1'b1, PAD_CHAR};
        end else if (w_acc) begin
            if (w_letter) begin
                w_push       = 1'b1;
                w_push_entry = {1'b0, w_char};
                if (r_prev_sep && (r_word_cnt != {CNT_W{1'b1}})) begin
                    w_word_cnt_next = r_word_cnt + 1'b1;
                end
            end else if (!r_prev_sep) begin
                w_push       = 1'b1;
                w_push_entry = {in_last, PAD_CHAR};
            end else if (in_last) begin
                // Separator-terminated stream still needs its closing pad.
                w_push       = 1'b1;
                w_push_entry = {1'b1, PAD_CHAR};
            end
        end
    end

    assign w_stream_end = w_push & w_push_entry[8];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_RUN;
            r_prev_sep   <= 1'b1;
            r_word_cnt   <= '0;
            stream_done  <= 1'b0;
            stream_words <= '0;
        end else begin
            stream_done <= w_stream_end;
            r_word_cnt  <= w_word_cnt_next;
            if (w_acc) begin
                r_prev_sep <= ~w_letter;
            end
            if (w_stream_end) begin
                stream_words <= w_word_cnt_next;
                r_word_cnt   <= '0;
                r_prev_sep   <= 1'b1;
            end
            case (r_state)
                ST_RUN: begin
                    if (w_acc && w_letter && in_last) begin
                        r_state <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    if (!w_full) begin
                        r_state <= ST_RUN;
                    end
                end
                default: r_state <= ST_RUN;
            endcase
        end
    end

    norm_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (9)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (w_push),
        .push_data (w_push_entry),
        .pop       (out_ready & ~w_empty),
        .pop_data  (w_head),
        .full      (w_full),
        .empty     (w_empty)
    );

    assign out_valid = ~w_empty;
    assign out_data  = w_empty ? 8'h00 : w_head[7:0];
    assign out_last  = ~w_empty & w_head[8];

endmodule
`default_nettype wire
